// File: rtl/trap_report_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : trap_report_arbiter
// Purpose  : Collects one end-of-simulation trap report per hart, timestamps
//            each report with a free-running cycle counter, and serialises
//            the reports onto a single monitor interface, one per cycle,
//            using round-robin arbitration. Produces sticky completion
//            (all_done) and failure (any_bad) summaries.
// Ports    :
//   clk        in   clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   [NUM_HARTS]        per-hart report valid
//   req_ready  out  [NUM_HARTS]        per-hart slot empty (accepts report)
//   req_code   in   [NUM_HARTS*32]     per-hart trap code (hart i at 32i)
//   req_pc     in   [NUM_HARTS*32]     per-hart trap PC   (hart i at 32i)
//   req_instr  in   [NUM_HARTS*CNT_W]  per-hart retired instruction count
//   mon_valid  out  one-cycle strobe, mon_* fields valid
//   mon_hart   out  [HART_W] hart index of the report
//   mon_code   out  [32]     trap code
//   mon_pc     out  [32]     trap PC
//   mon_cycle  out  [CNT_W]  cycle counter captured at acceptance
//   mon_instr  out  [CNT_W]  instruction count captured at acceptance
//   all_done   out  every hart has been reported (sticky)
//   any_bad    out  some reported trap code was non-zero (sticky)
// Revision : 1.0  initial release
// ============================================================================
module trap_report_arbiter #(
  parameter int NUM_HARTS = 2,
  parameter int CNT_W     = 32,
  parameter int HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_HARTS-1:0]       req_valid,
  output logic [NUM_HARTS-1:0]       req_ready,
  input  logic [NUM_HARTS*32-1:0]    req_code,
  input  logic [NUM_HARTS*32-1:0]    req_pc,
  input  logic [NUM_HARTS*CNT_W-1:0] req_instr,
  output logic                       mon_valid,
  output logic [HART_W-1:0]          mon_hart,
  output logic [31:0]                mon_code,
  output logic [31:0]                mon_pc,
  output logic [CNT_W-1:0]           mon_cycle,
  output logic [CNT_W-1:0]           mon_instr,
  output logic                       all_done,
  output logic                       any_bad
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    PENDING  = 2'd1,
    REPORTED = 2'd2
  } slot_state_t;

  slot_state_t       state     [NUM_HARTS];
  logic [31:0]       cap_code  [NUM_HARTS];
  logic [31:0]       cap_pc    [NUM_HARTS];
  logic [CNT_W-1:0]  cap_instr [NUM_HARTS];
  logic [CNT_W-1:0]  cap_cycle [NUM_HARTS];
  logic [CNT_W-1:0]  cycle_cnt;
  logic [HART_W-1:0] rr_ptr;

  logic              grant_valid;
  logic [HART_W-1:0] grant_idx;
  logic              all_reported_next;
  int                scan_idx;

  // A slot accepts only while empty; readiness never depends on req_valid.
  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      req_ready[i] = (state[i] == EMPTY);
    end
  end

  // Round-robin search over pending slots starting at rr_ptr. The index is
  // wrapped by subtraction so non-power-of-two hart counts work.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_HARTS; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_HARTS) begin
        scan_idx = scan_idx - NUM_HARTS;
      end
      if (!grant_valid && state[scan_idx] == PENDING) begin
        grant_valid = 1'b1;
        grant_idx   = HART_W'(scan_idx);
      end
    end
  end

  // True when every slot will be REPORTED once this cycle's grant lands.
  always_comb begin
    all_reported_next = 1'b1;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (!(state[i] == REPORTED ||
            (grant_valid && grant_idx == HART_W'(i)))) begin
        all_reported_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      rr_ptr    <= '0;
      mon_valid <= 1'b0;
      mon_hart  <= '0;
      mon_code  <= '0;
      mon_pc    <= '0;
      mon_cycle <= '0;
      mon_instr <= '0;
      all_done  <= 1'b0;
      any_bad   <= 1'b0;
      for (int i = 0; i < NUM_HARTS; i++) begin
        state[i]     <= EMPTY;
        cap_code[i]  <= '0;
        cap_pc[i]    <= '0;
        cap_instr[i] <= '0;
        cap_cycle[i] <= '0;
      end
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;

      // Acceptance into an empty slot and a grant of a pending slot touch
      // different slots, so both can happen in the same cycle.
      for (int i = 0; i < NUM_HARTS; i++) begin
        if (state[i] == EMPTY && req_valid[i]) begin
          state[i]     <= PENDING;
          cap_code[i]  <= req_code[32*i +: 32];
          cap_pc[i]    <= req_pc[32*i +: 32];
          cap_instr[i] <= req_instr[CNT_W*i +: CNT_W];
          cap_cycle[i] <= cycle_cnt;
        end else if (state[i] == PENDING && grant_valid &&
                     grant_idx == HART_W'(i)) begin
          state[i] <= REPORTED;
        end
      end

      mon_valid <= grant_valid;
      if (grant_valid) begin
        mon_hart  <= grant_idx;
        mon_code  <= cap_code[grant_idx];
        mon_pc    <= cap_pc[grant_idx];
        mon_cycle <= cap_cycle[grant_idx];
        mon_instr <= cap_instr[grant_idx];
        rr_ptr    <= (grant_idx == HART_W'(NUM_HARTS - 1)) ? '0
                                                           : grant_idx + 1'b1;
        if (all_reported_next) begin
          all_done <= 1'b1;
        end
        if (cap_code[grant_idx] != 32'd0) begin
          any_bad <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_report_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_report_arbiter
// Purpose  : Randomised plus directed bench for trap_report_arbiter with a
//            queue-based scoreboard fed by a rule-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_trap_report_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int HW = 2;

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_code  = '0;
  logic [N*32-1:0] req_pc    = '0;
  logic [N*CW-1:0] req_instr = '0;
  logic            mon_valid;
  logic [HW-1:0]   mon_hart;
  logic [31:0]     mon_code;
  logic [31:0]     mon_pc;
  logic [CW-1:0]   mon_cycle;
  logic [CW-1:0]   mon_instr;
  logic            all_done;
  logic            any_bad;

  trap_report_arbiter #(.NUM_HARTS(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_code(req_code), .req_pc(req_pc), .req_instr(req_instr),
    .mon_valid(mon_valid), .mon_hart(mon_hart), .mon_code(mon_code),
    .mon_pc(mon_pc), .mon_cycle(mon_cycle), .mon_instr(mon_instr),
    .all_done(all_done), .any_bad(any_bad)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            hart;
    logic [31:0]   code;
    logic [31:0]   pc;
    logic [CW-1:0] cyc;
    logic [CW-1:0] instr;
    time           due;
  } rep_t;

  rep_t exp_q[$];
  rep_t last;
  rep_t e;

  // Reference model: 0 = not yet reported, 1 = waiting, 2 = done.
  int            m_status [N];
  logic [31:0]   m_code   [N];
  logic [31:0]   m_pc     [N];
  logic [CW-1:0] m_cyc    [N];
  logic [CW-1:0] m_instr  [N];
  int            m_cnt;
  int            m_rr;
  bit            m_done;
  bit            m_bad;
  int            g;
  int            idx;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_status[i] = 0;
      m_code[i] = '0; m_pc[i] = '0; m_cyc[i] = '0; m_instr[i] = '0;
    end
    m_cnt = 0; m_rr = 0; m_done = 1'b0; m_bad = 1'b0;
    exp_q.delete();
    last.hart = 0; last.code = '0; last.pc = '0;
    last.cyc = '0; last.instr = '0; last.due = 0;
  endfunction

  // Model advances at every active edge from the inputs the bench applied.
  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_clear();
      end else begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (g < 0 && m_status[idx] == 1) g = idx;
        end
        if (g >= 0) begin
          m_status[g] = 2;
          m_rr = (g + 1) % N;
          if (m_code[g] != 0) m_bad = 1'b1;
          m_done = 1'b1;
          for (int i = 0; i < N; i++) if (m_status[i] != 2) m_done = 1'b0;
          e.hart = g; e.code = m_code[g]; e.pc = m_pc[g];
          e.cyc = m_cyc[g]; e.instr = m_instr[g]; e.due = $time + 5;
          exp_q.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
          if (m_status[i] == 0 && req_valid[i]) begin
            m_status[i] = 1;
            m_code[i]  = req_code[32*i +: 32];
            m_pc[i]    = req_pc[32*i +: 32];
            m_instr[i] = req_instr[CW*i +: CW];
            m_cyc[i]   = CW'(m_cnt);
          end
        end
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  logic [N-1:0] exp_ready;
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) exp_ready[i] = (m_status[i] == 0);
      chk("req_ready", req_ready, exp_ready);
      chk("all_done", all_done, m_done);
      chk("any_bad", any_bad, m_bad);
      if (mon_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", mon_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_time", $time, e.due);
          chk("mon_hart", mon_hart, e.hart);
          chk("mon_code", mon_code, e.code);
          chk("mon_pc", mon_pc, e.pc);
          chk("mon_cycle", mon_cycle, e.cyc);
          chk("mon_instr", mon_instr, e.instr);
          last = e;
        end
      end else begin
        while (exp_q.size() > 0 && exp_q[0].due <= $time) begin
          chk("missed_strobe", mon_valid, 1'b1);
          void'(exp_q.pop_front());
        end
        chk("hold_hart", mon_hart, last.hart);
        chk("hold_code", mon_code, last.code);
        chk("hold_pc", mon_pc, last.pc);
        chk("hold_cycle", mon_cycle, last.cyc);
        chk("hold_instr", mon_instr, last.instr);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_hart(input int i, input logic [31:0] code,
                          input logic [31:0] pc, input logic [CW-1:0] instr);
    req_code[32*i +: 32]  = code;
    req_pc[32*i +: 32]    = pc;
    req_instr[CW*i +: CW] = instr;
    req_valid[i]          = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    for (int k = 0; k < 40 && m_cnt != v; k++) step();
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 0;

    // Single hart accepted at counter 5.
    wait_cnt(5);
    set_hart(0, 32'h0, 32'h8000_0010, 4'd10);
    step(); req_valid = '0;
    repeat (5) step();

    // Acceptance right at the counter wrap point.
    wait_cnt(15);
    set_hart(1, 32'h5, 32'h8000_0100, 4'd3);
    step(); req_valid = '0;
    repeat (5) step();

    // Simultaneous reports, codes 0 and 1.
    do_reset();
    set_hart(0, 32'h0, 32'h1000, 4'd1);
    set_hart(1, 32'h1, 32'h2000, 4'd2);
    step(); req_valid = '0;
    repeat (5) step();

    // Round-robin fairness: hart1 first, then 0, 2, 3 together.
    do_reset();
    set_hart(1, 32'h0, 32'h11, 4'd4);
    step(); req_valid = '0;
    repeat (4) step();
    set_hart(0, 32'h0, 32'h20, 4'd5);
    set_hart(2, 32'h0, 32'h22, 4'd6);
    set_hart(3, 32'h7, 32'h33, 4'd7);
    step(); req_valid = '0;
    repeat (8) step();

    // Duplicate report: valid held for 10 cycles.
    do_reset();
    set_hart(0, 32'h9, 32'h44, 4'd8);
    repeat (10) step();
    req_valid = '0;
    repeat (4) step();

    // Reset while a hart is pending.
    do_reset();
    step();
    set_hart(2, 32'h3, 32'h55, 4'd9);
    @(posedge clk);
    #1 req_valid = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_mon_valid", mon_valid, 1'b0);
    chk("rst_req_ready", req_ready, {N{1'b1}});
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (5) step();
    wait_cnt(3);
    set_hart(3, 32'h0, 32'h66, 4'd11);
    step(); req_valid = '0;
    repeat (5) step();

    // Randomised rounds.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        for (int i = 0; i < N; i++) begin
          req_valid[i] = ($urandom_range(0, 3) == 0);
          req_code[32*i +: 32]  = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
          req_pc[32*i +: 32]    = $urandom;
          req_instr[CW*i +: CW] = CW'($urandom);
        end
        step();
      end
      req_valid = '1;
      step();
      req_valid = '0;
      repeat (8) step();
    end

    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
